// File: rtl/burst_rd_ctrl_if.sv
// rtl/burst_rd_ctrl_if.sv - request, device and response channels of the burst read controller
interface burst_rd_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH  = 3
);
    localparam int BEN_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic [1:0]            req_size;
    logic                  req_vld;
    logic                  req_rdy;
    logic                  dev_req;
    logic [ADDR_WIDTH-1:0] dev_addr;
    logic                  dev_ack;
    logic [DATA_WIDTH-1:0] dev_data;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [BEN_WIDTH-1:0]  rsp_ben;
    logic                  rsp_last;

    modport slave (
        input  req_addr, req_len, req_size, req_vld, dev_ack, dev_data, rsp_rdy,
        output req_rdy, dev_req, dev_addr, rsp_vld, rsp_data, rsp_ben, rsp_last
    );

    modport master (
        output req_addr, req_len, req_size, req_vld, dev_ack, dev_data, rsp_rdy,
        input  req_rdy, dev_req, dev_addr, rsp_vld, rsp_data, rsp_ben, rsp_last
    );
endinterface

// File: rtl/burst_rd_ctrl.sv
// rtl/burst_rd_ctrl.sv - burst read sequencer: one device read per beat, 2-entry return FIFO
module burst_rd_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH  = 3
) (
    input  logic               clk,
    input  logic               rst,
    burst_rd_ctrl_if.slave     bus
);
    localparam int BEN_WIDTH = DATA_WIDTH / 8;
    localparam int CW        = LEN_WIDTH + 1;
    localparam logic [1:0] MAX_SIZE = 2'($clog2(BEN_WIDTH));

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [1:0]            size_q;
    logic [CW-1:0]         dev_cnt_q, rsp_cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            fifo_cnt_q;

    logic                  accept, push, pop;
    logic                  req_rdy, dev_req, rsp_vld, rsp_last;
    logic [1:0]            req_eff;
    logic [ADDR_WIDTH-1:0] req_base, beat_addr;
    logic [BEN_WIDTH-1:0]  rsp_ben;
    int                    lane_off, lane_cnt;

    assign req_eff   = (bus.req_size > MAX_SIZE) ? MAX_SIZE : bus.req_size;
    assign req_base  = (bus.req_addr >> req_eff) << req_eff;
    assign beat_addr = base_q + (ADDR_WIDTH'(rsp_cnt_q) << size_q);

    assign rsp_vld  = (fifo_cnt_q != 2'd0);
    assign rsp_last = rsp_vld && (rsp_cnt_q == {1'b0, len_q});
    assign push     = dev_req && bus.dev_ack;
    assign pop      = rsp_vld && bus.rsp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        req_rdy = 1'b0;
        accept  = 1'b0;
        dev_req = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                accept  = bus.req_vld;
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                dev_req = (dev_cnt_q <= {1'b0, len_q}) && (fifo_cnt_q != 2'd2);
                if (pop && rsp_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Base and step are both multiples of the beat size, so the lane offset is already aligned.
    always_comb begin
        rsp_ben  = '0;
        lane_off = int'(beat_addr & ADDR_WIDTH'(BEN_WIDTH - 1));
        lane_cnt = 1 << size_q;
        for (int i = 0; i < BEN_WIDTH; i++)
            rsp_ben[i] = rsp_vld && (i >= lane_off) && (i < lane_off + lane_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            dev_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else if (accept) begin
            base_q     <= req_base;
            len_q      <= bus.req_len;
            size_q     <= req_eff;
            dev_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.dev_data;
                wr_ptr_q        <= ~wr_ptr_q;
                dev_cnt_q       <= dev_cnt_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= ~rd_ptr_q;
                rsp_cnt_q <= rsp_cnt_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign bus.req_rdy  = req_rdy;
    assign bus.dev_req  = dev_req;
    assign bus.dev_addr = base_q + (ADDR_WIDTH'(dev_cnt_q) << size_q);
    assign bus.rsp_vld  = rsp_vld;
    assign bus.rsp_data = mem_q[rd_ptr_q];
    assign bus.rsp_ben  = rsp_ben;
    assign bus.rsp_last = rsp_last;
endmodule

// File: tb/tb_burst_rd_ctrl.sv
// tb/tb_burst_rd_ctrl.sv - directed and randomized bursts against a beat-level reference model
module tb_burst_rd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    burst_rd_ctrl_if bus ();

    burst_rd_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] model_addr(input logic [19:0] a, input int s, input int k);
        int eff;
        int step;
        eff  = (s > 3) ? 3 : s;
        step = 1 << eff;
        return 20'((int'(a) / step) * step + k * step);
    endfunction

    function automatic logic [7:0] model_ben(input logic [19:0] beat_addr, input int s);
        int eff;
        int bytes;
        int off;
        eff   = (s > 3) ? 3 : s;
        bytes = 1 << eff;
        off   = int'(beat_addr) % 8;
        if (bytes == 8) return 8'hFF;
        return 8'(((1 << bytes) - 1) << off);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_rdy"},  bus.req_rdy, 1);
        chk({tag, "_dev_req"},  bus.dev_req, 0);
        chk({tag, "_dev_addr"}, bus.dev_addr, 0);
        chk({tag, "_rsp_vld"},  bus.rsp_vld, 0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 0);
        chk({tag, "_rsp_ben"},  bus.rsp_ben, 0);
        chk({tag, "_rsp_last"}, bus.rsp_last, 0);
    endtask

    // One burst; abort_at >= 0 asserts reset once that many responses are complete.
    task automatic burst(input logic [19:0] a, input int l, input int s, input int ack_pct,
                         input int rdy_pct, input int hold, input bit slow, input int abort_at);
        logic [63:0] q[$];
        int  acked = 0;
        int  responded = 0;
        int  age = 0;
        int  last_n = -1;
        bit  done = 0;
        bit  exp_req, exp_vld, ack, rdy;
        @(negedge clk);
        chk("start_req_rdy", bus.req_rdy, 1);
        bus.req_addr = a;
        bus.req_len  = 3'(l);
        bus.req_size = 2'(s);
        bus.req_vld  = 1'b1;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            bus.req_vld = 1'b0;
            if (abort_at >= 0 && responded == abort_at) begin
                rst = 1'b1;
                bus.dev_ack = 1'b0;
                bus.rsp_rdy = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            chk("busy_req_rdy", bus.req_rdy, 0);
            exp_req = (acked <= l) && (acked - responded < 2);
            exp_vld = (acked > responded);
            chk("dev_req", bus.dev_req, exp_req);
            if (exp_req) chk("dev_addr", bus.dev_addr, model_addr(a, s, acked));
            chk("rsp_vld", bus.rsp_vld, exp_vld);
            if (exp_vld) begin
                chk("rsp_data", bus.rsp_data, q[0]);
                chk("rsp_ben",  bus.rsp_ben, model_ben(model_addr(a, s, responded), s));
                chk("rsp_last", bus.rsp_last, responded == l);
            end
            if (slow) begin
                if (exp_req) begin
                    age++;
                    ack = (age >= 4);
                end else begin
                    age = 0;
                    ack = 1'($urandom_range(0, 1));
                end
            end else begin
                ack = ($urandom_range(0, 99) < ack_pct);
            end
            rdy = (n >= hold) && ($urandom_range(0, 99) < rdy_pct);
            bus.dev_ack  = ack;
            bus.dev_data = {$urandom, $urandom};
            bus.rsp_rdy  = rdy;
            if (exp_req && ack) begin
                q.push_back(bus.dev_data);
                acked++;
                age = 0;
            end
            if (exp_vld && rdy) begin
                void'(q.pop_front());
                responded++;
                if (responded == l + 1) begin
                    done   = 1'b1;
                    last_n = n;
                end
            end
        end
        chk("burst_done", done, 1);
        @(negedge clk);
        bus.dev_ack = 1'b0;
        bus.rsp_rdy = 1'b0;
        chk("end_req_rdy", bus.req_rdy, 1);
        chk("end_rsp_vld", bus.rsp_vld, 0);
        chk("end_dev_req", bus.dev_req, 0);
        if (ack_pct == 100 && rdy_pct == 100 && hold == 0 && !slow)
            chk("throughput", 64'(last_n), 64'(l + 1));
    endtask

    initial begin
        bus.req_addr = '0;
        bus.req_len  = '0;
        bus.req_size = '0;
        bus.req_vld  = 1'b0;
        bus.dev_ack  = 1'b0;
        bus.dev_data = '0;
        bus.rsp_rdy  = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");
        bus.dev_ack  = 1'b1;
        bus.dev_data = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        bus.dev_ack = 1'b0;
        chk("stray_ack_rsp_vld", bus.rsp_vld, 0);
        chk("stray_ack_req_rdy", bus.req_rdy, 1);

        burst(20'h00013, 3, 2, 100, 100, 0, 1'b0, -1);
        burst(20'h00005, 7, 0, 100, 100, 6, 1'b0, -1);
        burst(20'h00040, 3, 3, 100, 100, 0, 1'b1, -1);
        burst(20'hFFFF8, 7, 3, 100, 100, 0, 1'b0, -1);
        burst(20'h00100, 3, 2, 100, 100, 0, 1'b0, 2);
        burst(20'h00222, 3, 1, 100, 100, 0, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            burst(20'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
